// File: rtl/fft_pkg.sv
// Shared constants and elaboration-time helpers for the FFT sequencer.
package fft_pkg;

   localparam logic [3:0] ST_IDLE         = 4'd0;
   localparam logic [3:0] ST_LOAD         = 4'd1;
   localparam logic [3:0] ST_COMPUTE      = 4'd2;
   localparam logic [3:0] ST_DRAIN        = 4'd3;
   localparam logic [3:0] ST_UNLOAD       = 4'd4;
   localparam logic [3:0] ST_UNLOAD_DRAIN = 4'd5;
   localparam logic [3:0] ST_DONE         = 4'd6;

   // Ceiling log2; exact for the power-of-two FFT lengths used here.
   function automatic int unsigned fft_log2(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < v) r = r + 1;
      return r;
   endfunction

   // Write-back lag: BRAM read latency plus butterfly pipeline latency.
   function automatic int unsigned fft_wb_depth(input int unsigned ram_lat,
                                                input int unsigned bf_lat);
      return ram_lat + bf_lat;
   endfunction

endpackage

// File: rtl/fft_wb_delay.sv
// Shift register carrying butterfly write-back addresses across the read + butterfly latency.
module fft_wb_delay
   import fft_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = 4
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          in_valid,
   input  logic [AW-1:0] in_a0,
   input  logic [AW-1:0] in_a1,
   output logic          out_valid,
   output logic [AW-1:0] out_a0,
   output logic [AW-1:0] out_a1
);

   localparam int unsigned W = 2 * AW + 1;

   logic [W-1:0] sr [DEPTH];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int unsigned i = 0; i < DEPTH; i++) sr[i] <= '0;
      end else begin
         sr[0] <= {in_valid, in_a0, in_a1};
         for (int unsigned i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
      end
   end

   assign {out_valid, out_a0, out_a1} = sr[DEPTH-1];

endmodule

// File: rtl/fft_ctrl.sv
// In-place radix-2 DIT FFT sequencer: load, log2(N) butterfly stages, paired unload, done pulse.
module fft_ctrl
   import fft_pkg::*;
#(
   parameter int unsigned N       = 16,
   parameter int unsigned RAM_LAT = 1,
   parameter int unsigned BF_LAT  = 3
) (
   input  logic                               clk,
   input  logic                               rstn,
   input  logic                               start_i,
   input  logic                               load_valid_i,
   output logic                               busy_o,
   output logic                               fft_ready_o,
   output logic [3:0]                         state_o,
   output logic [fft_log2(fft_log2(N))-1:0]   stage_o,
   output logic                               rd_en_o,
   output logic [fft_log2(N)-1:0]             rd_addr_x0_o,
   output logic [fft_log2(N)-1:0]             rd_addr_x1_o,
   output logic [fft_log2(N)-2:0]             twiddle_addr_o,
   output logic                               wr_en_x0_o,
   output logic                               wr_en_x1_o,
   output logic [fft_log2(N)-1:0]             wr_addr_x0_o,
   output logic [fft_log2(N)-1:0]             wr_addr_x1_o,
   output logic                               sel_load_o,
   output logic                               out_valid_o
);

   localparam int unsigned LOG2N = fft_log2(N);
   localparam int unsigned AW    = LOG2N;
   localparam int unsigned BW    = LOG2N - 1;
   localparam int unsigned TW    = LOG2N - 1;
   localparam int unsigned SW    = fft_log2(LOG2N);
   localparam int unsigned L     = fft_wb_depth(RAM_LAT, BF_LAT);
   localparam int unsigned CW    = fft_log2(L + RAM_LAT) + 1;

   logic [3:0]    state, state_nx;
   logic [AW-1:0] k, k_nx;
   logic [BW-1:0] b, b_nx;
   logic [SW-1:0] s, s_nx;
   logic [CW-1:0] cnt, cnt_nx;

   logic          rd_en_nx;
   logic [AW-1:0] rd_a0_nx, rd_a1_nx;
   logic [TW-1:0] tw_nx;
   logic          ld_wr_nx;
   logic [AW-1:0] ld_addr_nx;
   logic          push_nx;
   logic          unload_nx;
   logic          ready_nx;

   logic [AW-1:0] b_ext, half_c, pos_c, grp_c, a0_c, a1_c, tw_sh_c;
   logic          dl_v;
   logic [AW-1:0] dl_a0, dl_a1;
   logic [RAM_LAT-1:0] uv;

   // Butterfly operand addressing for stage s, butterfly b.
   assign b_ext   = AW'(b);
   assign half_c  = AW'(1) << s;
   assign pos_c   = b_ext & (half_c - AW'(1));
   assign grp_c   = b_ext >> s;
   assign a0_c    = ((grp_c << s) << 1) | pos_c;
   assign a1_c    = a0_c | half_c;
   assign tw_sh_c = pos_c << (AW'(LOG2N - 1) - AW'(s));

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= ST_IDLE;
         k     <= '0;
         b     <= '0;
         s     <= '0;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         k     <= k_nx;
         b     <= b_nx;
         s     <= s_nx;
         cnt   <= cnt_nx;
      end
   end

   always_comb begin
      state_nx   = state;
      k_nx       = k;
      b_nx       = b;
      s_nx       = s;
      cnt_nx     = cnt;
      rd_en_nx   = 1'b0;
      rd_a0_nx   = '0;
      rd_a1_nx   = '0;
      tw_nx      = '0;
      ld_wr_nx   = 1'b0;
      ld_addr_nx = '0;
      push_nx    = 1'b0;
      unload_nx  = 1'b0;
      ready_nx   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start_i) begin
               state_nx = ST_LOAD;
               k_nx     = '0;
               s_nx     = '0;
            end
         end
         ST_LOAD: begin
            if (load_valid_i) begin
               ld_wr_nx   = 1'b1;
               ld_addr_nx = k;
               k_nx       = k + AW'(1);
               if (k == AW'(N - 1)) begin
                  state_nx = ST_COMPUTE;
                  b_nx     = '0;
                  s_nx     = '0;
               end
            end
         end
         ST_COMPUTE: begin
            rd_en_nx = 1'b1;
            rd_a0_nx = a0_c;
            rd_a1_nx = a1_c;
            tw_nx    = TW'(tw_sh_c);
            push_nx  = 1'b1;
            if (b == BW'(N / 2 - 1)) begin
               state_nx = ST_DRAIN;
               b_nx     = '0;
               cnt_nx   = '0;
            end else begin
               b_nx = b + BW'(1);
            end
         end
         // No reads here, so the last write-back of a stage lands before the next stage reads.
         ST_DRAIN: begin
            if (cnt == CW'(L - 1)) begin
               b_nx = '0;
               if (s == SW'(LOG2N - 1)) begin
                  state_nx = ST_UNLOAD;
               end else begin
                  s_nx     = s + SW'(1);
                  state_nx = ST_COMPUTE;
               end
            end else begin
               cnt_nx = cnt + CW'(1);
            end
         end
         ST_UNLOAD: begin
            rd_en_nx  = 1'b1;
            rd_a0_nx  = {b, 1'b0};
            rd_a1_nx  = {b, 1'b1};
            unload_nx = 1'b1;
            if (b == BW'(N / 2 - 1)) begin
               state_nx = ST_UNLOAD_DRAIN;
               b_nx     = '0;
               cnt_nx   = '0;
            end else begin
               b_nx = b + BW'(1);
            end
         end
         ST_UNLOAD_DRAIN: begin
            if (cnt == CW'(RAM_LAT - 1)) state_nx = ST_DONE;
            else                         cnt_nx   = cnt + CW'(1);
         end
         ST_DONE: begin
            ready_nx = 1'b1;
            state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   fft_wb_delay #(
      .DEPTH (L),
      .AW    (AW)
   ) u_wb_delay (
      .clk       (clk),
      .rstn      (rstn),
      .in_valid  (push_nx),
      .in_a0     (rd_a0_nx),
      .in_a1     (rd_a1_nx),
      .out_valid (dl_v),
      .out_a0    (dl_a0),
      .out_a1    (dl_a1)
   );

   // Registered datapath controls; load writes and butterfly write-backs never coincide.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         busy_o         <= 1'b0;
         fft_ready_o    <= 1'b0;
         rd_en_o        <= 1'b0;
         rd_addr_x0_o   <= '0;
         rd_addr_x1_o   <= '0;
         twiddle_addr_o <= '0;
         wr_en_x0_o     <= 1'b0;
         wr_en_x1_o     <= 1'b0;
         wr_addr_x0_o   <= '0;
         wr_addr_x1_o   <= '0;
         sel_load_o     <= 1'b0;
         out_valid_o    <= 1'b0;
         uv             <= '0;
      end else begin
         busy_o         <= (state_nx != ST_IDLE);
         fft_ready_o    <= ready_nx;
         rd_en_o        <= rd_en_nx;
         rd_addr_x0_o   <= rd_a0_nx;
         rd_addr_x1_o   <= rd_a1_nx;
         twiddle_addr_o <= tw_nx;
         wr_en_x0_o     <= ld_wr_nx | dl_v;
         wr_en_x1_o     <= dl_v;
         wr_addr_x0_o   <= ld_wr_nx ? ld_addr_nx : (dl_v ? dl_a0 : '0);
         wr_addr_x1_o   <= dl_v ? dl_a1 : '0;
         sel_load_o     <= ld_wr_nx;
         uv             <= RAM_LAT'({uv, unload_nx});
         out_valid_o    <= uv[RAM_LAT-1];
      end
   end

   assign state_o = state;
   assign stage_o = s;

endmodule

// File: tb/tb_fft_ctrl.sv
// Directed bench for fft_ctrl (N=16, RAM_LAT=1, BF_LAT=3) with cycle-exact expectations.
module tb_fft_ctrl;

   logic       clk;
   logic       rstn;
   logic       start_i;
   logic       load_valid_i;
   logic       busy_o;
   logic       fft_ready_o;
   logic [3:0] state_o;
   logic [1:0] stage_o;
   logic       rd_en_o;
   logic [3:0] rd_addr_x0_o;
   logic [3:0] rd_addr_x1_o;
   logic [2:0] twiddle_addr_o;
   logic       wr_en_x0_o;
   logic       wr_en_x1_o;
   logic [3:0] wr_addr_x0_o;
   logic [3:0] wr_addr_x1_o;
   logic       sel_load_o;
   logic       out_valid_o;

   int n_vec = 0;
   int n_err = 0;

   fft_ctrl #(.N(16), .RAM_LAT(1), .BF_LAT(3)) dut (
      .clk            (clk),
      .rstn           (rstn),
      .start_i        (start_i),
      .load_valid_i   (load_valid_i),
      .busy_o         (busy_o),
      .fft_ready_o    (fft_ready_o),
      .state_o        (state_o),
      .stage_o        (stage_o),
      .rd_en_o        (rd_en_o),
      .rd_addr_x0_o   (rd_addr_x0_o),
      .rd_addr_x1_o   (rd_addr_x1_o),
      .twiddle_addr_o (twiddle_addr_o),
      .wr_en_x0_o     (wr_en_x0_o),
      .wr_en_x1_o     (wr_en_x1_o),
      .wr_addr_x0_o   (wr_addr_x0_o),
      .wr_addr_x1_o   (wr_addr_x1_o),
      .sel_load_o     (sel_load_o),
      .out_valid_o    (out_valid_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // i-th address (ascending) whose bit st is 0: the lower operand of each butterfly.
   function automatic int low_operand(input int st, input int i);
      int c, r;
      c = 0;
      r = -1;
      for (int v = 0; v < 16; v++) begin
         if (((v >> st) & 1) == 0) begin
            if (c == i) r = v;
            c++;
         end
      end
      return r;
   endfunction

   task automatic chk_all_zero(input string tag);
      chk({tag, " busy"},  32'(busy_o), 0);
      chk({tag, " ready"}, 32'(fft_ready_o), 0);
      chk({tag, " state"}, 32'(state_o), 0);
      chk({tag, " stage"}, 32'(stage_o), 0);
      chk({tag, " rd_en"}, 32'(rd_en_o), 0);
      chk({tag, " rd_a0"}, 32'(rd_addr_x0_o), 0);
      chk({tag, " rd_a1"}, 32'(rd_addr_x1_o), 0);
      chk({tag, " tw"},    32'(twiddle_addr_o), 0);
      chk({tag, " wr0"},   32'(wr_en_x0_o), 0);
      chk({tag, " wr1"},   32'(wr_en_x1_o), 0);
      chk({tag, " wa0"},   32'(wr_addr_x0_o), 0);
      chk({tag, " wa1"},   32'(wr_addr_x1_o), 0);
      chk({tag, " sel"},   32'(sel_load_o), 0);
      chk({tag, " ov"},    32'(out_valid_o), 0);
   endtask

   // One complete transform from a start pulse; t counts edges after the accepted start edge.
   task automatic run_full(input bit gapped, input bit hold);
      int ld_end, base, t_rdy, rel, relw, relu, st, i, a0;
      bit e_rd, e_w0, e_w1, e_sel, e_ov;
      int e_a0, e_a1, e_wa0, e_wa1;
      string p;
      ld_end = gapped ? 32 : 16;
      base   = ld_end + 1;
      t_rdy  = base + 57;
      for (int t = 0; t <= t_rdy + 1; t++) begin
         start_i      = (t == 0) || (hold && t < t_rdy);
         load_valid_i = gapped ? (t % 2 == 0) : 1'b1;
         @(negedge clk);
         p = $sformatf("g%0d t%0d", gapped, t);
         e_rd = 0; e_w0 = 0; e_w1 = 0; e_sel = 0; e_ov = 0;
         e_a0 = 0; e_a1 = 0; e_wa0 = 0; e_wa1 = 0;
         if (t >= 1 && t <= ld_end && (!gapped || t % 2 == 0)) begin
            e_w0 = 1; e_sel = 1;
            e_wa0 = gapped ? t / 2 - 1 : t - 1;
         end
         rel = t - base;
         if (rel >= 0 && rel < 48 && rel % 12 < 8) begin
            st = rel / 12; i = rel % 12; a0 = low_operand(st, i);
            e_rd = 1; e_a0 = a0; e_a1 = a0 + (1 << st);
            chk({p, " tw"},    32'(twiddle_addr_o), 32'((a0 & ((1 << st) - 1)) << (3 - st)));
            chk({p, " stage"}, 32'(stage_o), 32'(st));
         end
         relw = t - 4 - base;
         if (relw >= 0 && relw < 48 && relw % 12 < 8) begin
            st = relw / 12; i = relw % 12; a0 = low_operand(st, i);
            e_w0 = 1; e_w1 = 1; e_wa0 = a0; e_wa1 = a0 + (1 << st);
         end
         relu = t - (base + 48);
         if (relu >= 0 && relu < 8) begin
            e_rd = 1; e_a0 = 2 * relu; e_a1 = 2 * relu + 1;
         end
         if (t - (base + 49) >= 0 && t - (base + 49) < 8) e_ov = 1;
         chk({p, " rd_en"}, 32'(rd_en_o), 32'(e_rd));
         chk({p, " wr0"},   32'(wr_en_x0_o), 32'(e_w0));
         chk({p, " wr1"},   32'(wr_en_x1_o), 32'(e_w1));
         chk({p, " ov"},    32'(out_valid_o), 32'(e_ov));
         chk({p, " ready"}, 32'(fft_ready_o), 32'(t == t_rdy));
         chk({p, " busy"},  32'(busy_o), 32'(t < t_rdy));
         if (e_rd) begin
            chk({p, " rd_a0"}, 32'(rd_addr_x0_o), 32'(e_a0));
            chk({p, " rd_a1"}, 32'(rd_addr_x1_o), 32'(e_a1));
         end
         if (e_w0) begin
            chk({p, " wa0"}, 32'(wr_addr_x0_o), 32'(e_wa0));
            chk({p, " sel"}, 32'(sel_load_o), 32'(e_sel));
         end
         if (e_w1) chk({p, " wa1"}, 32'(wr_addr_x1_o), 32'(e_wa1));
         if (t == 0 || t == ld_end - 1) chk({p, " state"}, 32'(state_o), 1);
         if (t == ld_end)               chk({p, " state"}, 32'(state_o), 2);
         if (t == base + 48)            chk({p, " state"}, 32'(state_o), 4);
         if (t == base + 56)            chk({p, " state"}, 32'(state_o), 6);
         if (t == t_rdy)                chk({p, " state"}, 32'(state_o), 0);
      end
      start_i      = 1'b0;
      load_valid_i = 1'b0;
   endtask

   initial begin
      rstn         = 1'b0;
      start_i      = 1'b0;
      load_valid_i = 1'b0;
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      rstn = 1'b1;
      @(negedge clk);

      run_full(1'b0, 1'b0);
      run_full(1'b1, 1'b1);

      // Abort in the middle of stage 1, then a clean run must still take 74 cycles.
      start_i      = 1'b1;
      load_valid_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      repeat (32) @(negedge clk);
      chk("abort pre state", 32'(state_o), 2);
      chk("abort pre stage", 32'(stage_o), 1);
      chk("abort pre rd_en", 32'(rd_en_o), 1);
      #2 rstn = 1'b0;
      #1 chk_all_zero("abort");
      load_valid_i = 1'b0;
      @(negedge clk);
      chk_all_zero("abort hold");
      rstn = 1'b1;
      run_full(1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
